// File: rtl/apb_mem_bridge_if.sv
// APB3 completer signals plus the single-outstanding req/ready memory port.
// Modport slave is the bridge side; master is the APB requester + memory side.
interface apb_mem_bridge_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [31:0] paddr_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  logic        req_o;
  logic        req_rnw_o;
  logic [9:0]  req_addr_o;
  logic [31:0] req_wdata_o;
  logic        req_ready_i;
  logic [31:0] req_rdata_i;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, req_ready_i, req_rdata_i,
    output prdata_o, pready_o, pslverr_o, req_o, req_rnw_o, req_addr_o, req_wdata_o
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i, req_ready_i, req_rdata_i,
    input  prdata_o, pready_o, pslverr_o, req_o, req_rnw_o, req_addr_o, req_wdata_o
  );
endinterface

// File: rtl/apb_mem_bridge.sv
// APB3 window -> 1024x32 memory request bridge, one transfer in flight; access takes 2+k cycles (1 on decode error).
// APB is stalled (pready low) until memory answers or the optional timeout aborts with pslverr.
module apb_mem_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TIMEOUT   = 16
) (
  input logic             clk,
  input logic             reset_n,
  apb_mem_bridge_if.slave bus
);
  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          rnw_q, rnw_d;
  logic [9:0]    addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   prdata_q, prdata_d;
  logic          pready_q, pready_d;
  logic          pslverr_q, pslverr_d;
  logic          hit;

  assign hit = (bus.paddr_i[31:12] == BASE_ADDR[31:12]) && (bus.paddr_i[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    rnw_d     = rnw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.psel_i && bus.penable_i) begin
          if (hit) begin
            state_d = REQ;
            req_d   = 1'b1;
            rnw_d   = ~bus.pwrite_i;
            addr_d  = bus.paddr_i[11:2];
            wdata_d = bus.pwdata_i;
            cnt_d   = '0;
          end else begin
            state_d   = DONE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Ready is tested first so it wins over a coincident timeout.
        if (bus.req_ready_i) begin
          state_d  = DONE;
          req_d    = 1'b0;
          pready_d = 1'b1;
          prdata_d = rnw_q ? bus.req_rdata_i : 32'h0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = DONE;
          req_d     = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rnw_q     <= rnw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign bus.req_o       = req_q;
  assign bus.req_rnw_o   = rnw_q;
  assign bus.req_addr_o  = addr_q;
  assign bus.req_wdata_o = wdata_q;
  assign bus.prdata_o    = prdata_q;
  assign bus.pready_o    = pready_q;
  assign bus.pslverr_o   = pslverr_q;
endmodule

// File: doc/apb_mem_bridge.md
# apb_mem_bridge

APB completer that converts APB3 transfers into the single-outstanding `req_*` handshake of the simple memory interface. It sits directly upstream of that memory interface and maps a 4 KiB APB window onto its 1024 x 32-bit word space. It also decodes addresses, flags misaligned and out-of-window accesses, and optionally aborts on a memory stall with `pslverr_o`.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: window base; must be 4 KiB aligned (bits [11:0] zero).
- `TIMEOUT`, default 16: maximum number of cycles to wait for `req_ready_i`; 0 disables the timeout.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: **synchronous, active-low** reset.
- `psel_i` in 1: APB select.
- `penable_i` in 1: APB enable (access phase).
- `pwrite_i` in 1: 1 = write, 0 = read.
- `paddr_i` in 32: byte address.
- `pwdata_i` in 32: write data.
- `prdata_o` out 32: read data; valid while `pready_o` is high.
- `pready_o` out 1: transfer complete; one-cycle pulse.
- `pslverr_o` out 1: transfer error; qualified by `pready_o`.
- `req_o` out 1: memory request.
- `req_rnw_o` out 1: 1 = read, 0 = write.
- `req_addr_o` out 10: word address.
- `req_wdata_o` out 32: write data to memory.
- `req_ready_i` in 1: memory completes the request on the edge where `req_o` and `req_ready_i` are both high.
- `req_rdata_i` in 32: read data; valid in the same cycle as `req_ready_i`.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE, no access:** stays IDLE while `psel_i & penable_i` is low.
- **IDLE, access sampled:** when `psel_i & penable_i` is high, decode the address.
  - Valid access: `paddr_i[31:12] == BASE_ADDR[31:12]` and `paddr_i[1:0] == 0`.
  - Valid → go to REQ. Set `req_o = 1`, `req_rnw_o = ~pwrite_i`, `req_addr_o = paddr_i[11:2]`, `req_wdata_o = pwdata_i`. Clear the timeout counter.
  - Invalid → go to DONE with `pslverr_o = 1`, `prdata_o = 0`. No memory request is issued.
- **REQ:** `req_o` and the captured fields are held stable until completion.
  - `req_ready_i = 1` → go to DONE. Drop `req_o`. Set `prdata_o = req_rdata_i` for reads, 0 for writes. Set `pslverr_o = 0`.
  - Otherwise the counter increments. If `TIMEOUT != 0` and the counter reaches `TIMEOUT - 1`, go to DONE: drop `req_o`, set `pslverr_o = 1`, `prdata_o = 0`.
  - Ready and timeout in the same cycle: ready wins, and the transfer completes normally.
- **DONE:** `pready_o = 1` for exactly one cycle, then go to IDLE.
  - `pready_o`, `pslverr_o` and `prdata_o` clear back to 0 on leaving DONE.
  - The still-asserted `psel_i & penable_i` in DONE is ignored, so the same transfer cannot retrigger.
- **Counter width:** `$clog2(TIMEOUT+1)` bits, minimum 1. It never wraps.
- **Reset mid-operation:** `reset_n = 0` on any edge forces IDLE and zeroes all outputs, including a pending `req_o` and the counter.
- **Setup phase:** `psel_i` high with `penable_i` low is ignored. There is no pipelining: one transfer is in flight at most.

## Timing
- E0 is the edge that samples the APB access phase in IDLE. `req_o` rises after E0.
- Zero-wait memory (ready high at E1): `pready_o` is high after E1, so the APB access lasts 2 cycles.
- k memory wait cycles: `pready_o` is high after edge E(1+k), so the access lasts 2+k cycles.
- Decode error: `pready_o` / `pslverr_o` are high after E0, so the access lasts 1 cycle.
- Timeout: `pready_o` / `pslverr_o` are high after edge E(TIMEOUT). `req_o` is high for exactly `TIMEOUT` cycles.
- Back-to-back transfers: the next access phase is accepted at the earliest on the edge after DONE. This is guaranteed by the APB setup cycle.

## Test plan
- **Write then read:** write 32'hDEAD_BEEF to `paddr_i` 32'h0000_0010, then read the same address, with zero-wait memory. Required: `req_addr_o` = 4, `req_rnw_o` = 0 then 1, `prdata_o` = 32'hDEAD_BEEF, `pslverr_o` = 0, each access 2 cycles.
- **Wait states:** memory holds `req_ready_i` low for 3 cycles. Required: `req_o` and `req_addr_o` stable for 4 cycles, `pready_o` pulses once, access lasts 5 cycles.
- **Decode errors:** read at 32'h0000_0012 (misaligned), and write at 32'h0000_1000 with `BASE_ADDR` = 0 (out of window). Required: `req_o` never rises, `pready_o` and `pslverr_o` high for 1 cycle, `prdata_o` = 0.
- **Timeout:** with `TIMEOUT` = 4, memory never asserts ready. Required: `req_o` high for 4 cycles then drops, `pslverr_o` = 1 with `pready_o`, state returns to IDLE. A subsequent normal read succeeds.
- **Reset mid-request:** assert `reset_n` = 0 for one cycle while in REQ. Required: after that edge all outputs are 0 and state is IDLE; the next transfer completes normally.
- **Race and back-to-back:** `req_ready_i` rises on the timeout cycle, followed by 10 back-to-back random-address write/read pairs. Required: completion with `pslverr_o` = 0, and every read returns the data last written to its word.
